wrap_imem_ld: RTL and testbench
===============================

# wrap_imem_ld

Parametrised instruction memory for the core fetch path. It provides a registered fetch port with a ready/valid handshake and a loader write port with byte enables. After reset, a clear sequencer can optionally zero the whole array. Storage is one single-port synchronous RAM (one access per cycle), so the block arbitrates between the clear sequencer, the loader and fetch.

## Interface
Parameters:
- AW_WORD, 12, word-address width; DEPTH = 2**AW_WORD words of 32 bits (default 4096 words = 16 KiB)
- CLEAR_ON_RESET, 1, 1 = zero-fill the array after reset; 0 = skip straight to RUN
- ERR_DATA, 32'h0000_0013, word returned on a faulted fetch (RV32I NOP)

Ports:
- sclk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_rdy  out  1  fetch accepted this cycle when if_req=1
- if_rvalid  out  1  fetch response valid
- if_rdata  out  32  fetch data
- if_err  out  1  fetch response faulted (misaligned or out of range)
- ld_wr  in  1  loader write strobe
- ld_addr  in  32  loader byte address
- ld_be  in  4  loader byte enables; bit i covers bits [8i+7:8i]
- ld_wdata  in  32  loader write data
- ld_ack  out  1  loader write completed (one-cycle pulse)
- busy  out  1  clear sequence in progress

## Operation
- FSM states: CLEAR and RUN.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
  - CLEAR: a counter clr_idx runs 0..DEPTH-1 and writes 32'h0 to word clr_idx with all bytes enabled, one word per cycle.
  - At clr_idx = DEPTH-1 the FSM moves to RUN; the counter does not wrap.
- In CLEAR:
  - busy=1, if_rdy=0.
  - ld_wr is ignored and gives no ld_ack. The loader must wait for busy=0.
- In RUN, priority is loader over fetch:
  - if_rdy = ~ld_wr. It is combinational on ld_wr and does not depend on if_req.
  - When ld_wr and if_req are both high, the write executes and the fetch is not accepted. The requester holds if_req and if_addr until if_rdy=1.
- Loader write:
  - word index = ld_addr[AW_WORD+1:2].
  - Only bytes with ld_be[i]=1 are written.
  - ld_addr[1:0] is ignored.
  - If ld_addr[31:AW_WORD+2] != 0, the write is dropped and ld_ack still pulses.
- Fetch fault:
  - An accepted fetch faults if if_addr[1:0] != 0 or if_addr[31:AW_WORD+2] != 0.
  - On a fault there is no RAM access. The response is if_err=1 and if_rdata=ERR_DATA.
- Fetch success: if_rdata is RAM word if_addr[AW_WORD+1:2] and if_err=0.
- Hold: if_rdata and if_err hold their last response value until the next accepted fetch responds.

## Timing
- Reset values:
  - if_rvalid=0, if_rdata=0, if_err=0, ld_ack=0.
  - busy=CLEAR_ON_RESET.
  - if_rdy=0 while rstn=0.
- Clear duration: DEPTH cycles. busy falls at the first edge after clr_idx = DEPTH-1 is written, so the first possible if_rdy=1 is cycle DEPTH after rstn deasserts.
- Fetch latency: 1 cycle.
  - Accepted at edge N, then if_rvalid=1 and data on if_rdata after edge N+1.
  - Back-to-back fetches give one response per cycle.
  - if_rvalid is a single-cycle pulse per accepted fetch.
- Loader: write committed at edge N, ld_ack=1 for the cycle after edge N. Back-to-back writes give back-to-back acks.
- Read-after-write: a fetch accepted the cycle after a write to the same word returns the new data. There is no stale-data window.
- Reset asserted mid-clear or mid-fetch:
  - All outputs go to reset values immediately.
  - Any pending response is discarded.
  - The clear restarts from word 0 after release.
  - Array contents are undefined only for words not yet cleared.

## Test plan
- Reset release, CLEAR_ON_RESET=1, AW_WORD=4 -> busy=1 for 16 cycles, if_rdy=0; then a fetch of 0x3C returns 0x0000_0000, if_err=0.
- Load 0xDEADBEEF at 0x8 with be=4'b1111, then be=4'b0001 data 0x0000_0011 -> fetch 0x8 returns 0xDEADBE11, one cycle after accept; ld_ack pulses once per write.
- Same-cycle ld_wr and if_req to 0x8 -> if_rdy=0 that cycle; write lands; the held fetch is accepted next cycle and returns the newly written data.
- Fetches 0x2 (misaligned) and 0x40 (AW_WORD=4, out of range) -> if_rvalid=1, if_err=1, if_rdata=0x0000_0013; RAM contents unchanged.
- Streaming fetches of 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive if_rvalid pulses with matching data; with if_req low afterwards, if_rdata holds the 0x8 data.
- rstn pulsed low at clear word 7 -> outputs reset asynchronously; the clear restarts and busy stays high for a full DEPTH cycles after release.

Source files
------------

// File: rtl/wrap_imem_ld.sv
// Instruction memory with a registered ready/valid fetch port, a byte-enabled loader
// write port and an optional post-reset zero-fill, all sharing one single-port RAM.
module wrap_imem_ld #(
    parameter int unsigned AW_WORD        = 12,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [31:0] ERR_DATA       = 32'h0000_0013
) (
    input  logic        sclk,
    input  logic        rstn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_rdy,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ld_wr,
    input  logic [31:0] ld_addr,
    input  logic [3:0]  ld_be,
    input  logic [31:0] ld_wdata,
    output logic        ld_ack,
    output logic        busy
);

    localparam int unsigned DEPTH = 2 ** AW_WORD;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [AW_WORD-1:0]   r_clr_idx;
    logic [AW_WORD-1:0]   w_clr_idx_nxt;

    logic [31:0]          r_mem [DEPTH];
    logic [31:0]          r_ram_q;
    logic                 r_rvalid;
    logic                 r_err;
    logic                 r_seen;
    logic                 r_ld_ack;

    logic [AW_WORD-1:0]   w_if_idx;
    logic [AW_WORD-1:0]   w_ld_idx;
    logic                 w_if_oor;
    logic                 w_ld_oor;
    logic                 w_if_fault;
    logic                 w_unused_ld;

    logic                 w_mem_we;
    logic                 w_mem_re;
    logic [AW_WORD-1:0]   w_mem_idx;
    logic [3:0]           w_mem_be;
    logic [31:0]          w_mem_wdata;
    logic                 w_fetch_acc;
    logic                 w_ld_done;
    logic                 w_if_rdy;
    logic                 w_busy;

    assign w_if_idx    = if_addr[AW_WORD+1:2];
    assign w_ld_idx    = ld_addr[AW_WORD+1:2];
    assign w_if_oor    = |(if_addr >> (AW_WORD + 2));
    assign w_ld_oor    = |(ld_addr >> (AW_WORD + 2));
    assign w_if_fault  = w_if_oor | (|if_addr[1:0]);
    assign w_unused_ld = ^ld_addr[1:0];

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= RESET_STATE;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    // One RAM port per cycle: clear sequencer, else loader, else fetch.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_mem_we      = 1'b0;
        w_mem_re      = 1'b0;
        w_mem_idx     = w_if_idx;
        w_mem_be      = '0;
        w_mem_wdata   = '0;
        w_fetch_acc   = 1'b0;
        w_ld_done     = 1'b0;
        w_if_rdy      = 1'b0;
        w_busy        = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_busy      = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_idx   = r_clr_idx;
                w_mem_be    = '1;
                w_mem_wdata = '0;
                if (r_clr_idx == '1) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_clr_idx_nxt = r_clr_idx + 1'b1;
                end
            end
            ST_RUN: begin
                // RUN is the reset state when clearing is disabled, so rstn gates it.
                if (rstn) begin
                    w_if_rdy = ~ld_wr;
                    if (ld_wr) begin
                        w_ld_done = 1'b1;
                        w_mem_idx = w_ld_idx;
                        if (!w_ld_oor) begin
                            w_mem_we    = 1'b1;
                            w_mem_be    = ld_be;
                            w_mem_wdata = ld_wdata;
                        end
                    end else if (if_req) begin
                        w_fetch_acc = 1'b1;
                        w_mem_re    = ~w_if_fault;
                    end
                end
            end
            default: begin
                w_state_nxt = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (w_mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_mem_be[b]) begin
                    r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
                end
            end
        end
        if (w_mem_re) begin
            r_ram_q <= r_mem[w_mem_idx];
        end
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_seen   <= 1'b0;
            r_ld_ack <= 1'b0;
        end else begin
            r_rvalid <= w_fetch_acc;
            r_ld_ack <= w_ld_done;
            if (w_fetch_acc) begin
                r_err <= w_if_fault;
                if (!w_if_fault) begin
                    r_seen <= 1'b1;
                end
            end
        end
    end

    // r_seen masks the unreset RAM output register until a real word has been read.
    assign if_rdata  = r_err ? ERR_DATA : (r_seen ? r_ram_q : '0);
    assign if_err    = r_err;
    assign if_rvalid = r_rvalid;
    assign if_rdy    = w_if_rdy;
    assign ld_ack    = r_ld_ack;
    assign busy      = w_busy;

endmodule

// File: tb/tb_wrap_imem_ld.sv
// Randomized self-checking bench for wrap_imem_ld against a word-array reference model.
module tb_wrap_imem_ld;

    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] ERR   = 32'h0000_0013;

    logic        sclk = 1'b0;
    logic        rstn = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_rdy;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        ld_wr = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [3:0]  ld_be = '0;
    logic [31:0] ld_wdata = '0;
    logic        ld_ack;
    logic        busy;

    wrap_imem_ld #(
        .AW_WORD       (AW),
        .CLEAR_ON_RESET(1'b1),
        .ERR_DATA      (ERR)
    ) dut (
        .sclk     (sclk),
        .rstn     (rstn),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdy   (if_rdy),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .if_err   (if_err),
        .ld_wr    (ld_wr),
        .ld_addr  (ld_addr),
        .ld_be    (ld_be),
        .ld_wdata (ld_wdata),
        .ld_ack   (ld_ack),
        .busy     (busy)
    );

    always #5 sclk = ~sclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain word array plus the last response and a clear-cycle count.
    logic [31:0] m_mem [DEPTH];
    bit          m_run;
    int          m_clr_cycles;
    logic [31:0] m_rdata;
    bit          m_err;
    bit          m_last_acc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run        = 1'b0;
        m_clr_cycles = 0;
        m_rdata      = '0;
        m_err        = 1'b0;
        m_last_acc   = 1'b1;
    endtask

    // Called at posedge+1; drives one cycle of stimulus and checks the outcome.
    task automatic do_cycle(input bit req, input logic [31:0] a, input bit wr,
                            input logic [31:0] la, input logic [3:0] be, input logic [31:0] wd);
        bit exp_rv;
        bit exp_ack;
        int idx;
        if_req   = req;
        if_addr  = a;
        ld_wr    = wr;
        ld_addr  = la;
        ld_be    = be;
        ld_wdata = wd;
        #1;
        check_val("if_rdy", {31'b0, if_rdy}, {31'b0, (m_run && !wr)});
        check_val("busy", {31'b0, busy}, {31'b0, !m_run});
        exp_rv     = 1'b0;
        exp_ack    = 1'b0;
        m_last_acc = 1'b0;
        if (!m_run) begin
            m_clr_cycles++;
            if (m_clr_cycles == DEPTH) begin
                m_run = 1'b1;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end
        end else if (wr) begin
            exp_ack = 1'b1;
            if ((la / (DEPTH * 4)) == 0) begin
                idx = int'(la / 4);
                for (int b = 0; b < 4; b++)
                    if (be[b]) m_mem[idx][8*b +: 8] = wd[8*b +: 8];
            end
        end else if (req) begin
            exp_rv     = 1'b1;
            m_last_acc = 1'b1;
            if ((a % 4) != 0 || (a / (DEPTH * 4)) != 0) begin
                m_rdata = ERR;
                m_err   = 1'b1;
            end else begin
                m_rdata = m_mem[int'(a / 4)];
                m_err   = 1'b0;
            end
        end else begin
            m_last_acc = 1'b1;
        end
        @(posedge sclk);
        #1;
        check_val("if_rvalid", {31'b0, if_rvalid}, {31'b0, exp_rv});
        check_val("ld_ack", {31'b0, ld_ack}, {31'b0, exp_ack});
        check_val("if_rdata", if_rdata, m_rdata);
        check_val("if_err", {31'b0, if_err}, {31'b0, m_err});
    endtask

    task automatic idle();
        do_cycle(1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic fetch(input logic [31:0] a);
        do_cycle(1'b1, a, 1'b0, '0, '0, '0);
    endtask

    task automatic load(input logic [31:0] la, input logic [3:0] be, input logic [31:0] wd);
        do_cycle(1'b0, '0, 1'b1, la, be, wd);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rvalid"}, {31'b0, if_rvalid}, 32'd0);
        check_val({tag, "_rdata"}, if_rdata, 32'd0);
        check_val({tag, "_err"}, {31'b0, if_err}, 32'd0);
        check_val({tag, "_ack"}, {31'b0, ld_ack}, 32'd0);
        check_val({tag, "_busy"}, {31'b0, busy}, 32'd1);
        check_val({tag, "_rdy"}, {31'b0, if_rdy}, 32'd0);
    endtask

    task automatic release_and_clear();
        @(posedge sclk);
        #1;
        rstn = 1'b1;
        model_reset();
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 32'h4, 1'b0, '0, '0, '0);
    endtask

    initial begin
        bit          r_req;
        logic [31:0] r_a;
        bit          r_wr;
        logic [31:0] r_la;
        int          sel;

        model_reset();
        if_req = 1'b1;
        repeat (3) @(posedge sclk);
        #1;
        check_reset_outputs("reset");
        release_and_clear();

        fetch(32'h3C);
        load(32'h8, 4'b1111, 32'hDEAD_BEEF);
        load(32'hB, 4'b0001, 32'h0000_0011);
        fetch(32'h8);
        check_val("dir_deadbe11", if_rdata, 32'hDEAD_BE11);
        do_cycle(1'b1, 32'h8, 1'b1, 32'h8, 4'b1111, 32'hCAFE_F00D);
        fetch(32'h8);
        check_val("dir_raw", if_rdata, 32'hCAFE_F00D);
        fetch(32'h2);
        fetch(32'h40);
        load(32'h44, 4'b1111, 32'h1234_5678);
        fetch(32'h4);
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);
        idle();
        idle();
        check_val("dir_hold", if_rdata, 32'hCAFE_F00D);

        r_req = 1'b0;
        r_a   = '0;
        for (int n = 0; n < 400; n++) begin
            if (m_last_acc || !r_req) begin
                r_req = ($urandom_range(0, 9) < 6);
                sel   = $urandom_range(0, 9);
                if (sel < 8)       r_a = 32'(sel) * 4 + 32'(($urandom_range(0, 1)) * 32);
                else if (sel == 8) r_a = 32'($urandom_range(0, 63)) | 32'h1;
                else               r_a = $urandom() | 32'h100;
            end
            r_wr = ($urandom_range(0, 9) < 3);
            r_la = ($urandom_range(0, 9) == 0) ? ($urandom() | 32'h40) : 32'($urandom_range(0, 63));
            do_cycle(r_req, r_a, r_wr, r_la, 4'($urandom_range(0, 15)), $urandom());
        end

        fetch(32'h3C);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("midfetch");
        release_and_clear();

        for (int i = 0; i < 7; i++) do_cycle(1'b1, 32'h0, 1'b0, '0, '0, '0);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("midclear");
        release_and_clear();
        fetch(32'h3C);
        fetch(32'h1C);
        load(32'h1C, 4'b0110, 32'hA5A5_A5A5);
        fetch(32'h1C);
        check_val("post_clear_be", if_rdata, 32'h00A5_A500);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
